mask_memory_arb: RTL and testbench

MASK_MEMORY_ARB -- requirements
Module: mask_memory_arb

---
 rtl/mask_memory_arb.sv | 171 +++++++++++++++++
 tb/tb_mask_memory_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_memory_arb.sv
// mask_memory_arb: N-port round-robin arbiter in front of a single-port RAM.
// One access per cycle. Reads return two cycles after the grant, through a RAM
// register and then an output register. lock_en hands exclusive ownership to
// lock_port. The optional clear engine is compiled only when
// MASK_MEMORY_CLEAR_EN is defined. It zero-fills the RAM one word per cycle.
module mask_memory_arb #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 8,
  parameter int N_PORTS = 2,
  localparam int PW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS-1:0]          wren,
  input  logic [N_PORTS*ADDR_W-1:0]   address,
  input  logic [N_PORTS*DATA_W-1:0]   data_write,
  input  logic                        lock_en,
  input  logic [PW-1:0]               lock_port,
  input  logic                        clear,
  output logic [N_PORTS-1:0]          gnt,
  output logic                        busy,
  output logic                        rd_valid,
  output logic [PW-1:0]               rd_port,
  output logic [DATA_W-1:0]           data_read
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [N_PORTS-1:0][ADDR_W-1:0] addr_a;
  logic [N_PORTS-1:0][DATA_W-1:0] wdat_a;
  assign addr_a = address;
  assign wdat_a = data_write;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [1:0]        vld_pipe_q;
  logic [PW-1:0]     port1_q, rd_port_q;
  logic [DATA_W-1:0] data_read_q;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [N_PORTS-1:0] gnt_c;
  logic [PW-1:0]      gidx;
  logic               any_c, busy_c, rd_fire;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

`ifdef MASK_MEMORY_CLEAR_EN
  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  // Clear FSM state and sweep address register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state: sweep every address once, and ignore clear while sweeping
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_IDLE: begin
        clr_addr_d = '0;
        if (clear) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_c = (state_q == S_CLEAR);
  end
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign busy_c       = 1'b0;
`endif

  // Grant selection: lock owner only, or first requester at or after rr_ptr
  always_comb begin
    int idx;
    gnt_c = '0;
    gidx  = '0;
    any_c = 1'b0;
    idx   = 0;
    if (!rst && !busy_c) begin
      if (lock_en) begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (lock_port == PW'(i) && req[i]) begin
            gnt_c[i] = 1'b1;
            gidx     = PW'(i);
            any_c    = 1'b1;
          end
        end
      end else begin
        for (int k = 0; k < N_PORTS; k++) begin
          idx = int'(rr_ptr_q) + k;
          if (idx >= N_PORTS) idx = idx - N_PORTS;
          if (!any_c && req[idx]) begin
            gnt_c[idx] = 1'b1;
            gidx       = PW'(idx);
            any_c      = 1'b1;
          end
        end
      end
    end
  end

  assign gnt     = gnt_c;
  assign rd_fire = any_c & ~wren[gidx];
  // A locked grant leaves the pointer where it is
  assign rr_ptr_d = (!any_c || lock_en) ? rr_ptr_q :
                    (gidx == PW'(N_PORTS - 1)) ? '0 : gidx + 1'b1;

  // RAM write port: the clear sweep and port grants never overlap
  always_comb begin
    mem_we    = any_c & wren[gidx];
    mem_waddr = addr_a[gidx];
    mem_wdata = wdat_a[gidx];
`ifdef MASK_MEMORY_CLEAR_EN
    if (busy_c) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = '0;
    end
`endif
  end

  // RAM array and its read register. Contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we)  mem[mem_waddr] <= mem_wdata;
    if (rd_fire) ram_q <= mem[addr_a[gidx]];
  end

  // Read pipeline, output registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      port1_q     <= '0;
      rd_port_q   <= '0;
      data_read_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], rd_fire};
      rr_ptr_q   <= rr_ptr_d;
      if (rd_fire) port1_q <= gidx;
      if (vld_pipe_q[0]) begin
        data_read_q <= ram_q;
        rd_port_q   <= port1_q;
      end
    end
  end

  assign busy      = busy_c;
  assign rd_valid  = vld_pipe_q[1];
  assign rd_port   = rd_port_q;
  assign data_read = data_read_q;

endmodule

// File: tb/tb_mask_memory_arb.sv
// Self-checking bench for mask_memory_arb (N_PORTS=3, ADDR_W=4, DATA_W=32).
// The reference model keeps the memory as an array. Pending reads sit in a
// queue keyed by their due cycle. Grants come from the round-robin rule.
module tb_mask_memory_arb;
  localparam int N = 3, AW = 4, DW = 32, PW = 2, DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req, wren;
  logic [N*AW-1:0]  address;
  logic [N*DW-1:0]  data_write;
  logic             lock_en;
  logic [PW-1:0]    lock_port;
  logic             clear;
  logic [N-1:0]     gnt;
  logic             busy, rd_valid;
  logic [PW-1:0]    rd_port;
  logic [DW-1:0]    data_read;

  mask_memory_arb #(.DATA_W(DW), .ADDR_W(AW), .N_PORTS(N)) dut (
    .clk(clk), .rst(rst), .req(req), .wren(wren), .address(address),
    .data_write(data_write), .lock_en(lock_en), .lock_port(lock_port),
    .clear(clear), .gnt(gnt), .busy(busy), .rd_valid(rd_valid),
    .rd_port(rd_port), .data_read(data_read)
  );

  typedef struct { int due; int port; logic [DW-1:0] data; } rd_t;

  int            tests = 0, failed = 0;
  int            cyc = 0, rr_m = 0, clr_left = 0;
  int            cnt_v = 0, cnt_b = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last_data = '0;
  rd_t           rq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    last_data = '0;
    rr_m      = 0;
    clr_left  = 0;
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int lp, i;
    g = '0;
    if (rst || clr_left > 0) return g;
    if (lock_en) begin
      lp = int'(lock_port);
      if (lp < N && req[lp]) g[lp] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      i = (rr_m + k) % N;
      if (req[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Check the current cycle against the model, then advance one clock.
  task automatic step();
    logic [N-1:0] eg;
    int           gi, a;
    bit           ev;
    rd_t          r;
    #1;
    if (rst) model_reset();
    eg = model_gnt();
    ev = (rq.size() > 0 && rq[0].due == cyc);
    r  = '{0, 0, '0};
    if (ev) begin
      r = rq.pop_front();
      last_data = r.data;
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("busy", 64'(busy), 64'(clr_left > 0));
    chk("rd_valid", 64'(rd_valid), 64'(ev));
    chk("data_read", 64'(data_read), 64'(last_data));
    if (ev) chk("rd_port", 64'(rd_port), 64'(r.port));
    if (rd_valid) cnt_v++;
    if (busy) cnt_b++;
    @(posedge clk);
    if (!rst) begin
      gi = -1;
      for (int i = 0; i < N; i++) if (eg[i]) gi = i;
      if (gi >= 0) begin
        a = int'(address[gi*AW +: AW]);
        if (wren[gi]) mem_m[a] = data_write[gi*DW +: DW];
        else rq.push_back('{cyc + 2, gi, mem_m[a]});
        if (!lock_en) rr_m = (gi + 1) % N;
      end
`ifdef MASK_MEMORY_CLEAR_EN
      if (clr_left > 0) begin
        mem_m[DEPTH - clr_left] = '0;
        clr_left--;
      end else if (clear) begin
        clr_left = DEPTH;
      end
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive1(input int p, input bit we, input int a, input logic [DW-1:0] d);
    req = '0; wren = '0; address = '0; data_write = '0;
    req[p] = 1'b1;
    wren[p] = we;
    address[p*AW +: AW] = AW'(a);
    data_write[p*DW +: DW] = d;
  endtask

  task automatic idle(input int n);
    req = '0; wren = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; req = '1; wren = '0; address = '0; data_write = '0;
    lock_en = 1'b0; lock_port = '0; clear = 1'b0;
    @(negedge clk);
    // Reset: requests are gated and every output is zero
    step();
    rst = 1'b0;

    // Fill all words
    for (int a = 0; a < DEPTH; a++) begin
      drive1(0, 1'b1, a, 32'hFFFF_FFFF);
      step();
    end

    // Port 0 writes, port 1 reads back the next cycle
    drive1(0, 1'b1, 10, 32'hA5A5_A5A5);
    step();
    drive1(1, 1'b0, 10, '0);
    step();
    idle(1);
    #1;
    chk("wr_rd_valid", 64'(rd_valid), 64'd1);
    chk("wr_rd_port", 64'(rd_port), 64'd1);
    chk("wr_rd_data", 64'(data_read), 64'hA5A5_A5A5);
    step();

    // Reset with reads still in flight
    drive1(2, 1'b0, 3, '0);
    step();
    drive1(0, 1'b0, 4, '0);
    step();
    rst = 1'b1; req = '1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(data_read), 64'd0);
    step();
    rst = 1'b0;

    // Round-robin from a freshly reset pointer
    req = 3'b111; wren = '0; address = {4'd2, 4'd1, 4'd0};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_seq", 64'(gnt), 64'(1 << (k % 3)));
      step();
    end
    idle(3);

    // Lock to port 1, then to a non-existent port
    lock_en = 1'b1; lock_port = 2'd1; req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lock_gnt", 64'(gnt), 64'b010);
      step();
    end
    lock_port = 2'd3;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("lock_none", 64'(gnt), 64'd0);
      step();
    end
    lock_en = 1'b0;
    idle(3);

    // Back-to-back reads
    cnt_v = 0;
    for (int a = 0; a < 8; a++) begin
      drive1(0, 1'b0, a, '0);
      step();
    end
    idle(3);
    chk("b2b_count", 64'(cnt_v), 64'd8);

    // Clear pulse while requests keep arriving
    clear = 1'b1; req = '0;
    step();
    clear = 1'b0; cnt_b = 0;
    for (int k = 0; k < 20; k++) begin
      req = 3'($urandom); wren = 3'($urandom);
      address = 12'($urandom); data_write = {$urandom, $urandom, $urandom};
      step();
    end
`ifdef MASK_MEMORY_CLEAR_EN
    chk("clear_busy_cycles", 64'(cnt_b), 64'd16);
`else
    chk("clear_busy_cycles", 64'(cnt_b), 64'd0);
`endif
    for (int a = 0; a < DEPTH; a++) begin
      drive1(a % N, 1'b0, a, '0);
      step();
    end
    idle(3);

    // Random traffic with occasional lock, clear and reset
    for (int k = 0; k < 400; k++) begin
      req        = 3'($urandom);
      wren       = 3'($urandom);
      address    = 12'($urandom);
      data_write = {$urandom, $urandom, $urandom};
      lock_en    = ($urandom_range(7) == 0);
      lock_port  = 2'($urandom);
      clear      = ($urandom_range(39) == 0);
      rst        = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0; lock_en = 1'b0; clear = 1'b0;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
